// File: rtl/regfile_pkg.sv
// Shared definitions for the uPOWER register file and its port controller.
// Sizes and the controller FSM encoding live here so both sides agree.
package regfile_pkg;

    localparam int N     = 64;
    localparam int R     = 32;
    localparam int ASIZE = $clog2(R);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_port_ctrl.sv
// Port controller for the 32 x 64b register file: sequences the registered
// two-operand read with write-after-read bypass and forwards writebacks.
//
// Handshakes: a transfer fires on a rising edge where valid & ready are both
// high; the initiator holds valid and payload until then, and ready may depend
// combinationally on the partner's valid/ready but never the other way round.
module regfile_port_ctrl
    import regfile_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_req_valid,
    output logic             o_rd_req_ready,
    input  logic [ASIZE-1:0] i_rd_ra,
    input  logic [ASIZE-1:0] i_rd_rb,
    output logic             o_rd_rsp_valid,
    input  logic             i_rd_rsp_ready,
    output logic [N-1:0]     o_rd_rsp_a,
    output logic [N-1:0]     o_rd_rsp_b,
    input  logic             i_wb_valid,
    output logic             o_wb_ready,
    input  logic [ASIZE-1:0] i_wb_rd,
    input  logic [N-1:0]     i_wb_data,
    output logic [ASIZE-1:0] o_rf_reg_id_r1,
    output logic [ASIZE-1:0] o_rf_reg_id_r2,
    output logic [ASIZE-1:0] o_rf_reg_id_w,
    output logic [N-1:0]     o_rf_data_in,
    output logic             o_rf_wr,
    input  logic [N-1:0]     i_rf_data_out1,
    input  logic [N-1:0]     i_rf_data_out2,
    output state_e           o_state
);

    state_e           r_state;
    state_e           w_next;
    logic             w_req_ready;
    logic             w_req_fire;
    logic             w_wb_fire;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [ASIZE-1:0] r_rf_id1;
    logic [ASIZE-1:0] r_rf_id2;
    logic             r_hit_a;
    logic             r_hit_b;
    logic [N-1:0]     r_byp_a;
    logic [N-1:0]     r_byp_b;
    logic             r_rsp_valid;
    logic [N-1:0]     r_rsp_a;
    logic [N-1:0]     r_rsp_b;

    // Write port is a straight pass-through; only reset can hold it off.
    assign o_wb_ready    = ~i_rst;
    assign o_rf_wr       = i_wb_valid & ~i_rst;
    assign o_rf_reg_id_w = i_wb_rd;
    assign o_rf_data_in  = i_wb_data;
    assign w_wb_fire     = i_wb_valid & o_wb_ready;

    assign o_rd_req_ready = w_req_ready & ~i_rst;
    assign w_req_fire     = i_rd_req_valid & o_rd_req_ready;

    // A write landing on the register file's sampling edge is invisible to
    // the read, so it must be caught here.
    assign w_hit_a = w_wb_fire && (i_wb_rd == r_rf_id1);
    assign w_hit_b = w_wb_fire && (i_wb_rd == r_rf_id2);

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (i_rd_req_valid) w_next = ISSUE;
            end
            ISSUE: w_next = CAPT;
            CAPT:  w_next = RESP;
            RESP: begin
                w_req_ready = i_rd_rsp_ready;
                if (i_rd_rsp_ready) w_next = i_rd_req_valid ? ISSUE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rf_id1    <= '0;
            r_rf_id2    <= '0;
            r_hit_a     <= 1'b0;
            r_hit_b     <= 1'b0;
            r_byp_a     <= '0;
            r_byp_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
        end else begin
            r_state <= w_next;
            if (w_req_fire) begin
                r_rf_id1 <= i_rd_ra;
                r_rf_id2 <= i_rd_rb;
            end
            case (r_state)
                ISSUE: begin
                    r_hit_a <= w_hit_a;
                    r_hit_b <= w_hit_b;
                    if (w_hit_a) r_byp_a <= i_wb_data;
                    if (w_hit_b) r_byp_b <= i_wb_data;
                end
                CAPT: begin
                    r_rsp_a     <= r_hit_a ? r_byp_a : i_rf_data_out1;
                    r_rsp_b     <= r_hit_b ? r_byp_b : i_rf_data_out2;
                    r_rsp_valid <= 1'b1;
                    r_hit_a     <= 1'b0;
                    r_hit_b     <= 1'b0;
                end
                RESP: begin
                    if (i_rd_rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_rf_reg_id_r1 = r_rf_id1;
    assign o_rf_reg_id_r2 = r_rf_id2;
    assign o_rd_rsp_valid = r_rsp_valid;
    assign o_rd_rsp_a     = r_rsp_a;
    assign o_rd_rsp_b     = r_rsp_b;
    assign o_state        = r_state;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural register file
// (registered read, write commits at the edge, read-old on same-edge write).
module tb_regfile_port_ctrl;
    import regfile_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rd_req_valid = 1'b0;
    logic             rd_req_ready;
    logic [ASIZE-1:0] rd_ra = '0;
    logic [ASIZE-1:0] rd_rb = '0;
    logic             rd_rsp_valid;
    logic             rd_rsp_ready = 1'b0;
    logic [N-1:0]     rd_rsp_a;
    logic [N-1:0]     rd_rsp_b;
    logic             wb_valid = 1'b0;
    logic             wb_ready;
    logic [ASIZE-1:0] wb_rd = '0;
    logic [N-1:0]     wb_data = '0;
    logic [ASIZE-1:0] rf_id_r1;
    logic [ASIZE-1:0] rf_id_r2;
    logic [ASIZE-1:0] rf_id_w;
    logic [N-1:0]     rf_data_in;
    logic             rf_wr;
    logic [N-1:0]     rf_out1;
    logic [N-1:0]     rf_out2;
    state_e           dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] mem [R];

    always #5 clk = ~clk;

    regfile_port_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rd_req_valid (rd_req_valid),
        .o_rd_req_ready (rd_req_ready),
        .i_rd_ra        (rd_ra),
        .i_rd_rb        (rd_rb),
        .o_rd_rsp_valid (rd_rsp_valid),
        .i_rd_rsp_ready (rd_rsp_ready),
        .o_rd_rsp_a     (rd_rsp_a),
        .o_rd_rsp_b     (rd_rsp_b),
        .i_wb_valid     (wb_valid),
        .o_wb_ready     (wb_ready),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_rf_reg_id_r1 (rf_id_r1),
        .o_rf_reg_id_r2 (rf_id_r2),
        .o_rf_reg_id_w  (rf_id_w),
        .o_rf_data_in   (rf_data_in),
        .o_rf_wr        (rf_wr),
        .i_rf_data_out1 (rf_out1),
        .i_rf_data_out2 (rf_out2),
        .o_state        (dbg_state)
    );

    // Register file model driven only by the controller's rf_* outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < R; i++) mem[i] <= '0;
            rf_out1 <= '0;
            rf_out2 <= '0;
        end else begin
            if (rf_wr) mem[rf_id_w] <= rf_data_in;
            rf_out1 <= mem[rf_id_r1];
            rf_out2 <= mem[rf_id_r2];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ASIZE-1:0] a, input logic [N-1:0] d);
        wb_valid = 1'b1;
        wb_rd    = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    // Presents a request and holds it until the accept edge has passed.
    task automatic send_req(input logic [ASIZE-1:0] a, input logic [ASIZE-1:0] b);
        rd_req_valid = 1'b1;
        rd_ra        = a;
        rd_rb        = b;
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input string name);
        int n;
        n = 0;
        while (!rd_rsp_valid && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (rd_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: rd_rsp_valid=%b after %0d cycles, expected 1", name, rd_rsp_valid, n);
        end
    endtask

    task automatic consume();
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_valid = 1'b1;
        #1;
        n_tests++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", rd_req_ready); end
        n_tests++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wb_ready: got %b expected 0", wb_ready); end
        n_tests++; if (rf_wr !== 1'b0) begin n_fail++; $display("FAIL rst_rf_wr: got %b expected 0", rf_wr); end
        n_tests++; if (rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rd_rsp_valid); end
        n_tests++; if (rd_rsp_a !== 64'h0 || rd_rsp_b !== 64'h0) begin n_fail++; $display("FAIL rst_rsp_data: got a=%h b=%h expected 0", rd_rsp_a, rd_rsp_b); end
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected IDLE", dbg_state); end
        wb_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got wb=%b req=%b expected 1 1", wb_ready, rd_req_ready); end
    endtask

    task automatic test_basic_read();
        do_write(5'd5, 64'h11);
        do_write(5'd9, 64'h22);
        rd_req_valid = 1'b1;
        rd_ra = 5'd5;
        rd_rb = 5'd9;
        #1;
        n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready: got %b expected 1", rd_req_ready); end
        tick();
        n_tests++; if (rd_req_ready !== 1'b0 || dbg_state !== ISSUE) begin n_fail++; $display("FAIL basic_issue: ready=%b state=%0d expected 0 ISSUE", rd_req_ready, dbg_state); end
        n_tests++; if (rf_id_r1 !== 5'd5 || rf_id_r2 !== 5'd9) begin n_fail++; $display("FAIL basic_addr: got %0d %0d expected 5 9", rf_id_r1, rf_id_r2); end
        tick();
        n_tests++; if (rd_req_ready !== 1'b0 || rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_capt: ready=%b valid=%b expected 0 0", rd_req_ready, rd_rsp_valid); end
        rd_req_valid = 1'b0;
        tick();
        n_tests++; if (rd_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid=%b expected 1", rd_rsp_valid); end
        n_tests++; if (rd_rsp_a !== 64'h11 || rd_rsp_b !== 64'h22) begin n_fail++; $display("FAIL basic_data: got a=%h b=%h expected 11 22", rd_rsp_a, rd_rsp_b); end
        consume();
        n_tests++; if (rd_rsp_valid !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL basic_release: valid=%b state=%0d expected 0 IDLE", rd_rsp_valid, dbg_state); end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 64'h01);
        send_req(5'd7, 5'd7);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 64'hAB;
        tick();
        wb_valid = 1'b0;
        tick();
        n_tests++; if (rd_rsp_a !== 64'hAB || rd_rsp_b !== 64'hAB) begin n_fail++; $display("FAIL bypass_data: got a=%h b=%h expected ab ab", rd_rsp_a, rd_rsp_b); end
        consume();
    endtask

    task automatic test_accept_edge_write();
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 64'h55;
        send_req(5'd3, 5'd0);
        wb_valid = 1'b0;
        tick();
        tick();
        n_tests++; if (rd_rsp_a !== 64'h55 || rd_rsp_b !== 64'h0) begin n_fail++; $display("FAIL accept_write: got a=%h b=%h expected 55 0", rd_rsp_a, rd_rsp_b); end
        consume();
    endtask

    task automatic test_snapshot();
        do_write(5'd4, 64'h10);
        send_req(5'd4, 5'd4);
        wait_rsp(4, "snap1");
        n_tests++; if (rd_rsp_a !== 64'h10) begin n_fail++; $display("FAIL snap_first: got a=%h expected 10", rd_rsp_a); end
        do_write(5'd4, 64'h99);
        tick();
        n_tests++; if (rd_rsp_valid !== 1'b1 || rd_rsp_a !== 64'h10 || rd_rsp_b !== 64'h10) begin n_fail++; $display("FAIL snap_hold: valid=%b a=%h b=%h expected 1 10 10", rd_rsp_valid, rd_rsp_a, rd_rsp_b); end
        consume();
        send_req(5'd4, 5'd4);
        wait_rsp(4, "snap2");
        n_tests++; if (rd_rsp_a !== 64'h99 || rd_rsp_b !== 64'h99) begin n_fail++; $display("FAIL snap_follow: got a=%h b=%h expected 99 99", rd_rsp_a, rd_rsp_b); end
        consume();
    endtask

    task automatic test_back_to_back();
        do_write(5'd10, 64'hA0);
        do_write(5'd11, 64'hB0);
        send_req(5'd10, 5'd11);
        wait_rsp(4, "b2b1");
        rd_req_valid = 1'b1;
        rd_ra = 5'd11;
        rd_rb = 5'd10;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_a !== 64'hA0 || rd_rsp_b !== 64'hB0 || rd_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_stall%0d: valid=%b a=%h b=%h ready=%b expected 1 a0 b0 0", i, rd_rsp_valid, rd_rsp_a, rd_rsp_b, rd_req_ready);
            end
        end
        rd_rsp_ready = 1'b1;
        #1;
        n_tests++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_follow: got %b expected 1", rd_req_ready); end
        tick();
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b0;
        n_tests++; if (dbg_state !== ISSUE || rf_id_r1 !== 5'd11 || rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_issue: state=%0d r1=%0d valid=%b expected ISSUE 11 0", dbg_state, rf_id_r1, rd_rsp_valid); end
        tick();
        tick();
        n_tests++; if (rd_rsp_valid !== 1'b1 || rd_rsp_a !== 64'hB0 || rd_rsp_b !== 64'hA0) begin n_fail++; $display("FAIL b2b_second: valid=%b a=%h b=%h expected 1 b0 a0", rd_rsp_valid, rd_rsp_a, rd_rsp_b); end
        consume();
    endtask

    task automatic test_reset_mid();
        do_write(5'd12, 64'h77);
        send_req(5'd12, 5'd12);
        tick();
        n_tests++; if (dbg_state !== CAPT) begin n_fail++; $display("FAIL rmid_precond: state=%0d expected CAPT", dbg_state); end
        rst = 1'b1;
        wb_valid = 1'b1;
        #1;
        n_tests++; if (dbg_state !== IDLE || rd_rsp_valid !== 1'b0 || rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: state=%0d valid=%b ready=%b expected IDLE 0 0", dbg_state, rd_rsp_valid, rd_req_ready); end
        n_tests++; if (rf_id_r1 !== 5'd0 || rf_id_r2 !== 5'd0 || rd_rsp_a !== 64'h0 || rf_wr !== 1'b0 || wb_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_outs: r1=%0d r2=%0d a=%h wr=%b wbr=%b expected all 0", rf_id_r1, rf_id_r2, rd_rsp_a, rf_wr, wb_ready); end
        wb_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        n_tests++; if (rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp: valid=%b expected 0", rd_rsp_valid); end
        send_req(5'd12, 5'd12);
        wait_rsp(4, "rmid");
        n_tests++; if (rd_rsp_a !== 64'h0 || rd_rsp_b !== 64'h0) begin n_fail++; $display("FAIL rmid_cleared: got a=%h b=%h expected 0 0", rd_rsp_a, rd_rsp_b); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_bypass();
        test_accept_edge_write();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Initiator-side port controller that drives the 32 x 64b register file in the uPOWER datapath. It accepts two-operand read requests from decode over a valid/ready handshake and sequences the register file's registered read. It returns both operands with write-after-read bypass, and forwards writeback requests onto the register file's single write port. It sits between decode/writeback and the register file, so no other block drives the register file ports directly.

## Interface
- N, 64, data width per register
- R, 32, number of registers
- ASIZE, $clog2(R), register address width
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high; same net drives the register file's rst
- rd_req_valid  in  1  operand read request valid
- rd_req_ready  out  1  controller can accept a request this cycle
- rd_ra  in  ASIZE  first operand register id
- rd_rb  in  ASIZE  second operand register id
- rd_rsp_valid  out  1  operand response valid
- rd_rsp_ready  in  1  consumer takes response this cycle
- rd_rsp_a  out  N  value of register rd_ra
- rd_rsp_b  out  N  value of register rd_rb
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted this cycle
- wb_rd  in  ASIZE  writeback destination
- wb_data  in  N  writeback value
- rf_reg_id_r1  out  ASIZE  register file read address 1 (registered)
- rf_reg_id_r2  out  ASIZE  register file read address 2 (registered)
- rf_reg_id_w  out  ASIZE  register file write address
- rf_data_in  out  N  register file write data
- rf_wr  out  1  register file write enable
- rf_data_out1  in  N  register file read data 1
- rf_data_out2  in  N  register file read data 2

## Operation
- Register file contract: read addresses are sampled at a posedge, and data_out is valid after that same edge. A write commits at a posedge. A read sampled on the same edge as a write to the same register returns the OLD value.
- Write path is combinational pass-through: rf_wr = wb_valid & ~rst, rf_reg_id_w = wb_rd, rf_data_in = wb_data, wb_ready = ~rst. A write fires when wb_valid & wb_ready.
- FSM states: IDLE, ISSUE, CAPT, RESP.
  - IDLE: rd_req_ready=1. On request fire, latch rd_ra/rd_rb into rf_reg_id_r1/r2 and go to ISSUE.
  - ISSUE: the register file samples the addresses at the exiting edge. If a write fires on this edge with wb_rd == rf_reg_id_r1, latch wb_data into bypass A and set hit_a; do the same independently for B. Go to CAPT.
  - CAPT: on the exiting edge, load rd_rsp_a = hit_a ? byp_a : rf_data_out1, and likewise for B. Set rd_rsp_valid. Clear hits. Go to RESP.
  - RESP: hold rd_rsp_* stable until rd_rsp_ready.
    - On rd_rsp_ready & ~rd_req_valid: go to IDLE.
    - On rd_rsp_ready & rd_req_valid: accept the new request (rd_req_ready = rd_rsp_ready in RESP), latch its addresses and go to ISSUE.
- Writes that fire while in CAPT or RESP do not alter a loaded response; the response is a snapshot.
- Writes that fire on or before the accept edge are seen through the register file.
- ra == rb is legal; both outputs carry the same value, and bypass applies to both.
- Register 0 gets no special handling.

## Timing
- Reset values: state IDLE, rd_rsp_valid 0, rd_rsp_a/b 0, rf_reg_id_r1/r2 0, hit_a/hit_b 0, bypass regs 0. rd_req_ready is 0 and wb_ready is 0 while rst is high. rf_wr is 0 while rst is high.
- Reset mid-operation drops any in-flight request and response immediately; no response is emitted for it.
- Latency: accept at edge E0 leads to rd_rsp_valid high after edge E0+2.
- Throughput: one request per 3 cycles with a consumer that is always ready.
- Writeback latency: a write is committed at the edge where it fires; zero added cycles.

## Structure
- Shared package regfile_pkg holds N, R, ASIZE and the FSM state enum (IDLE/ISSUE/CAPT/RESP). The same package is reused by the register file.
- No sub-module: the bypass compare and mux are two instances of inline logic. The FSM and datapath stay in one module.

## Test plan
- Preload r5=0x11, r9=0x22. Request ra=5, rb=9 -> rd_rsp_valid after 3 edges with a=0x11, b=0x22. rd_req_ready is 0 during ISSUE and CAPT.
- Request ra=rb=7, and fire write r7=0xAB on the ISSUE-exit edge -> a=b=0xAB (bypass hit).
- Write r3=0x55 on the accept edge, then request ra=3 -> a=0x55 via the register file, with no bypass.
- Write r4=0x99 during RESP after the response reads r4=0x10 -> response stays 0x10. A follow-up request returns 0x99.
- Hold rd_rsp_ready=0 for 5 cycles with the next request pending -> outputs stable. On ready, the next request is accepted in the same cycle and issued back-to-back.
- Assert rst while in CAPT -> all outputs are 0 immediately and state is IDLE. After release, the next request returns correct data (0 after the register file clears).
